// File: rtl/stream_mux_n.sv
// rtl/stream_mux_n.sv - N-to-1 valid/ready stream mux with packet locking and a registered output stage
module stream_mux_n #(
  parameter int DWidth = 32,
  parameter int NumIn = 5,
  localparam int SelWidth = $clog2(NumIn)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NumIn*DWidth-1:0] data_i,
  input  logic [NumIn-1:0]        valid_i,
  input  logic [NumIn-1:0]        last_i,
  output logic [NumIn-1:0]        ready_o,
  input  logic                    mode_i,
  input  logic [SelWidth-1:0]     select_i,
  output logic [DWidth-1:0]       data_o,
  output logic                    valid_o,
  output logic                    last_o,
  input  logic                    ready_i,
  output logic [SelWidth-1:0]     grant_o
);

  localparam logic [SelWidth:0]   NumInW  = (SelWidth+1)'(NumIn);
  localparam logic [SelWidth-1:0] LastIdx = SelWidth'(NumIn - 1);

  logic [SelWidth-1:0] rr_ptr;
  logic [SelWidth-1:0] lock_idx;
  logic                locked;

  logic [SelWidth-1:0] rr_g;
  logic                rr_found;
  logic [SelWidth:0]   rr_idx;
  logic [SelWidth-1:0] g;
  logic                gv;
  logic [DWidth-1:0]   g_data;
  logic                g_valid;
  logic                g_last;
  logic                space;
  logic                accept;

  // Round-robin scan starting at rr_ptr, wrapping modulo NumIn.
  always_comb begin
    rr_found = 1'b0;
    rr_g     = '0;
    rr_idx   = '0;
    for (int i = 0; i < NumIn; i++) begin
      rr_idx = {1'b0, rr_ptr} + (SelWidth+1)'(i);
      if (rr_idx >= NumInW) rr_idx = rr_idx - NumInW;
      if (!rr_found && valid_i[rr_idx[SelWidth-1:0]]) begin
        rr_found = 1'b1;
        rr_g     = rr_idx[SelWidth-1:0];
      end
    end
  end

  // A held packet lock overrides both arbitration modes.
  always_comb begin
    if (locked) begin
      gv = 1'b1;
      g  = lock_idx;
    end else if (!mode_i) begin
      gv = ({1'b0, select_i} < NumInW);
      g  = select_i;
    end else begin
      gv = rr_found;
      g  = rr_g;
    end
  end

  always_comb begin
    g_data  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    for (int k = 0; k < NumIn; k++) begin
      if (g == SelWidth'(k)) begin
        g_data  = data_i[k*DWidth +: DWidth];
        g_valid = valid_i[k];
        g_last  = last_i[k];
      end
    end
  end

  assign space  = !valid_o || ready_i;
  assign accept = gv && g_valid && space;

  always_comb begin
    ready_o = '0;
    for (int k = 0; k < NumIn; k++) begin
      ready_o[k] = rst_n && gv && space && (g == SelWidth'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o   <= '0;
      valid_o  <= 1'b0;
      last_o   <= 1'b0;
      grant_o  <= '0;
      rr_ptr   <= '0;
      locked   <= 1'b0;
      lock_idx <= '0;
    end else begin
      if (accept) begin
        data_o  <= g_data;
        last_o  <= g_last;
        grant_o <= g;
        valid_o <= 1'b1;
        locked  <= !g_last;
        if (!g_last) lock_idx <= g;
        // Pointer only advances past a source once its packet has ended.
        if (g_last && mode_i) rr_ptr <= (g == LastIdx) ? '0 : g + SelWidth'(1);
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_n.sv
// tb/tb_stream_mux_n.sv - randomized and directed bench for stream_mux_n against a behavioural model
module tb_stream_mux_n;
  localparam int DW = 32;
  localparam int N  = 5;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*DW-1:0] data_i;
  logic [N-1:0]    valid_i;
  logic [N-1:0]    last_i;
  logic [N-1:0]    ready_o;
  logic            mode_i;
  logic [SW-1:0]   select_i;
  logic [DW-1:0]   data_o;
  logic            valid_o;
  logic            last_o;
  logic            ready_i;
  logic [SW-1:0]   grant_o;

  always #5 clk = ~clk;

  stream_mux_n #(.DWidth(DW), .NumIn(N)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
    .ready_o(ready_o), .mode_i(mode_i), .select_i(select_i), .data_o(data_o),
    .valid_o(valid_o), .last_o(last_o), .ready_i(ready_i), .grant_o(grant_o)
  );

  int checks = 0;
  int errors = 0;

  int          m_locked, m_lock_idx, m_rr, m_valid, m_last, m_grant;
  logic [DW-1:0] m_data;
  logic [DW-1:0] sb_q[$];
  logic [N-1:0]  obs_ready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_lock_idx = 0; m_rr = 0;
    m_valid = 0; m_last = 0; m_grant = 0; m_data = '0;
    sb_q.delete();
  endtask

  function automatic int model_grant();
    if (m_locked != 0) return m_lock_idx;
    if (mode_i == 1'b0) return (int'(select_i) < N) ? int'(select_i) : -1;
    for (int i = 0; i < N; i++) begin
      if (valid_i[(m_rr + i) % N]) return (m_rr + i) % N;
    end
    return -1;
  endfunction

  // Called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic step();
    int g;
    logic [N-1:0] er;
    bit sp, acc;
    #1;
    g  = model_grant();
    sp = (m_valid == 0) || ready_i;
    er = '0;
    if (g >= 0 && sp) er[g] = 1'b1;
    obs_ready = ready_o;
    check("ready_o", ready_o, er);
    acc = (g >= 0) && sp && valid_i[g];
    if (m_valid != 0 && ready_i) begin
      if (sb_q.size() == 0) check("sb_underflow", 1, 0);
      else check("sb_order", data_o, sb_q.pop_front());
    end
    if (acc) begin
      m_data  = data_i[g*DW +: DW];
      m_last  = last_i[g];
      m_grant = g;
      m_valid = 1;
      sb_q.push_back(m_data);
      if (last_i[g]) begin
        m_locked = 0;
        if (mode_i) m_rr = (g + 1) % N;
      end else begin
        m_locked = 1;
        m_lock_idx = g;
      end
    end else if (ready_i) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    check("valid_o", valid_o, m_valid);
    if (m_valid != 0) begin
      check("data_o", data_o, m_data);
      check("last_o", last_o, m_last);
      check("grant_o", grant_o, m_grant);
    end
  endtask

  task automatic rand_data();
    for (int k = 0; k < N; k++) data_i[k*DW +: DW] = $urandom();
  endtask

  int seq[7] = '{0, 1, 2, 3, 4, 0, 1};
  logic [DW-1:0] hold_d;
  logic [SW-1:0] hold_g;

  initial begin
    rst_n = 1'b0; data_i = '0; valid_i = '1; last_i = '1;
    mode_i = 1'b0; select_i = '0; ready_i = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_last", last_o, 0);
    check("rst_grant", grant_o, 0);
    check("rst_ready", ready_o, 0);
    rst_n = 1'b1;

    // Explicit select of channel 2
    valid_i = 5'b00100; select_i = 3'd2; rand_data();
    data_i[2*DW +: DW] = 32'hA5A5_0002;
    #1 check("sel_ready", ready_o, 5'b00100);
    step();
    check("sel_data", data_o, 32'hA5A5_0002);
    check("sel_grant", grant_o, 2);
    valid_i = '0;
    step();

    // Out-of-range select: no grant
    valid_i = '1; select_i = 3'd7;
    for (int i = 0; i < 10; i++) begin
      rand_data();
      step();
      check("oor_ready", obs_ready, 0);
      check("oor_valid", valid_o, 0);
    end

    // Round-robin single-beat packets
    mode_i = 1'b1; last_i = '1; valid_i = '1;
    for (int i = 0; i < 7; i++) begin
      rand_data();
      step();
      check("rr_seq", grant_o, seq[i]);
    end

    // Lock on ch1 with a mid-packet valid gap
    valid_i = 5'b00001; rand_data(); step();
    valid_i = 5'b01011; last_i = 5'b11101; rand_data(); step();
    check("lk_grant1", grant_o, 1);
    rand_data(); step();
    valid_i = 5'b01001;
    for (int i = 0; i < 2; i++) begin
      rand_data(); step();
      check("lk_block", obs_ready & 5'b01001, 0);
    end
    valid_i = 5'b01011; last_i = '1; rand_data(); step();
    check("lk_last", grant_o, 1);
    valid_i = 5'b01001; rand_data(); step();
    check("lk_next", grant_o, 3);

    // Downstream stall
    valid_i = '1; last_i = '1; rand_data(); step();
    hold_d = data_o; hold_g = grant_o;
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_data(); step();
      check("stall_ready", obs_ready, 0);
      check("stall_data", data_o, hold_d);
      check("stall_grant", grant_o, hold_g);
    end
    ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin rand_data(); step(); end

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rand_data();
      valid_i = '0; last_i = '0;
      for (int k = 0; k < N; k++) begin
        valid_i[k] = ($urandom_range(0, 9) < 7);
        last_i[k]  = ($urandom_range(0, 9) < 6);
      end
      if ($urandom_range(0, 9) == 0) mode_i = ~mode_i;
      select_i = SW'($urandom_range(0, 7));
      ready_i  = ($urandom_range(0, 3) != 0);
      step();
    end

    // Reset while locked on ch2
    mode_i = 1'b1; ready_i = 1'b1; valid_i = '0; last_i = '1; step();
    valid_i = 5'b00100; last_i = 5'b11011; rand_data(); step();
    check("prerst_grant", grant_o, 2);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mrst_valid", valid_o, 0);
    check("mrst_data", data_o, 0);
    check("mrst_grant", grant_o, 0);
    check("mrst_ready", ready_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    valid_i = '1; last_i = '1; rand_data(); step();
    check("post_rst_grant", grant_o, 0);
    rand_data(); step();
    check("post_rst_grant2", grant_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
